// File: rtl/fact_sel_pipe.sv
// fact_sel_pipe
// -------------
// Registered operand selector feeding the factorial multiplier. Each accepted
// request picks one of NCH operand channels, or the constant CONST_VAL when
// force_const is high. The chosen operand is queued in a 2-entry FIFO. The
// head entry is the output register and the tail entry is the skid register.
// Multiplier backpressure therefore never drops or repeats an operand.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     upstream presents an operand request
//   in_ready     block can accept a request (registered, state-only)
//   force_const  1: select CONST_VAL; sel and in_data are ignored
//   sel          channel index used when force_const=0
//   in_data      NCH packed channels, channel k at [k*WIDTH +: WIDTH]
//   out_valid    out_data holds a valid operand
//   out_ready    downstream accepts the operand this cycle
//   out_data     selected operand (head of the FIFO)
//   sel_err      sticky: a request was accepted with an out-of-range sel
//   count        operands delivered, modulo 2**16
module fact_sel_pipe #(
    parameter int                 WIDTH     = 32,
    parameter int                 NCH       = 2,
    parameter int                 SEL_W     = 4,
    parameter logic [WIDTH-1:0]   CONST_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  force_const,
    input  logic [SEL_W-1:0]      sel,
    input  logic [NCH*WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  sel_err,
    output logic [15:0]           count
);

    // The extra bit lets a 4-bit sel be compared against NCH=16.
    localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(NCH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Returns channel s of d. An index with no matching channel returns zero.
    function automatic logic [WIDTH-1:0] pick_chan(
        input logic [NCH*WIDTH-1:0] d,
        input logic [SEL_W-1:0]     s
    );
        logic [WIDTH-1:0] res;
        res = {WIDTH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if ({1'b0, s} == (SEL_W+1)'(k)) begin
                res = d[k*WIDTH +: WIDTH];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t             r_state;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_sel_err;
    logic [15:0]        r_count;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_head_nxt;
    logic [WIDTH-1:0]   w_tail_nxt;
    logic               w_accept;
    logic               w_deliver;
    logic               w_sel_bad;
    logic [WIDTH-1:0]   w_sel_data;

    // Handshake qualifiers and the operand selected at accept time
    always_comb begin
        w_accept  = in_valid & r_in_ready;
        w_deliver = r_out_valid & out_ready;
        w_sel_bad = ~force_const & ({1'b0, sel} >= NCH_L);
        if (force_const) begin
            w_sel_data = CONST_VAL;
        end else begin
            w_sel_data = pick_chan(in_data, sel);
        end
    end

    // FIFO next-state logic: the head always holds the oldest operand
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = w_sel_data;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    w_head_nxt  = w_sel_data;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_tail_nxt  = w_sel_data;
                end else if (w_deliver) begin
                    // The head value is kept; it is don't-care while out_valid is 0.
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is 0 here, so no accept can happen.
                if (w_deliver) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = r_tail;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State, storage and flags. The handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_head      <= {WIDTH{1'b0}};
            r_tail      <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_sel_err   <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
            if (w_accept && w_sel_bad) begin
                r_sel_err <= 1'b1;
            end else begin
                r_sel_err <= r_sel_err;
            end
            if (w_deliver) begin
                r_count <= r_count + 16'd1;
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;
    assign sel_err   = r_sel_err;
    assign count     = r_count;

endmodule

// File: tb/tb_fact_sel_pipe.sv
// Scoreboard testbench for fact_sel_pipe (NCH=4, WIDTH=32, CONST_VAL=1).
// The driver pushes each expected operand when its request is accepted.
// A negedge monitor pops and compares on every deliver cycle.
module tb_fact_sel_pipe;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            force_const = 1'b0;
    logic [SW-1:0]   sel = 4'd0;
    logic [N*W-1:0]  in_data = {N*W{1'b0}};
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic            sel_err;
    logic [15:0]     count;

    logic [W-1:0]    sb[$];
    logic [W-1:0]    exp_v;
    logic [15:0]     exp_count = 16'd0;
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;

    localparam logic [N*W-1:0] D_STD = {32'h44, 32'h33, 32'h22, 32'h11};

    fact_sel_pipe #(.WIDTH(W), .NCH(N), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .force_const(force_const), .sel(sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_err(sel_err), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one deliver per negedge where out_valid & out_ready
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_count = 16'd0;
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got 0x%0h want none", out_data);
            end else begin
                exp_v = sb.pop_front();
                chk("out_data", out_data, exp_v);
            end
            chk("count_at_deliver", {16'd0, count}, {16'd0, exp_count});
            exp_count = exp_count + 16'd1;
        end
    end

    // Present one request; push its expectation once it will be accepted.
    task automatic send(input logic fc, input logic [SW-1:0] s,
                        input logic [N*W-1:0] d, input logic [W-1:0] e);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        force_const = fc;
        sel = s;
        in_data = d;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready 0 want 1");
            in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int base;
        int t0;
        // Reset state
        idle(2);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Forced constant with sel out of range: constant wins, no sel_err
        out_ready = 1'b1;
        send(1'b1, 4'd7, D_STD, 32'd1);
        chk("const_valid", {31'd0, out_valid}, 32'd1);
        chk("const_data", out_data, 32'd1);
        idle(1);
        chk("const_count", {16'd0, count}, 32'd1);
        chk("const_sel_err", {31'd0, sel_err}, 32'd0);

        // Channel selection, back-to-back requests in ONE
        send(1'b0, 4'd2, D_STD, 32'h33);
        chk("sel2_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("sel2_data", out_data, 32'h33);
        send(1'b0, 4'd0, D_STD, 32'h11);
        chk("sel0_data", out_data, 32'h11);
        send(1'b0, 4'd3, D_STD, 32'h44);
        chk("sel3_data", out_data, 32'h44);
        chk("sel_err_clean", {31'd0, sel_err}, 32'd0);
        idle(2);

        // Backpressure: fill to FULL, hold off the third request, then drain
        base = int'(count);
        out_ready = 1'b0;
        send(1'b0, 4'd0, {32'h44, 32'h33, 32'h22, 32'hA}, 32'hA);
        send(1'b0, 4'd0, {32'h44, 32'h33, 32'h22, 32'hB}, 32'hB);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data = {32'h44, 32'h33, 32'h22, 32'hC};
        for (int i = 0; i < 3; i++) begin
            chk("holdoff_in_ready", {31'd0, in_ready}, 32'd0);
            chk("holdoff_head", out_data, 32'hA);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(1'b0, 4'd0, {32'h44, 32'h33, 32'h22, 32'hC}, 32'hC);
        idle(1);
        chk("bp_count3", count - 16'(base), 32'd3);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Out-of-range sel: zero operand, sticky sel_err
        send(1'b0, 4'd7, D_STD, 32'd0);
        chk("bad_sel_data", out_data, 32'd0);
        chk("bad_sel_err", {31'd0, sel_err}, 32'd1);
        send(1'b0, 4'd1, D_STD, 32'h22);
        send(1'b1, 4'd0, D_STD, 32'd1);
        idle(2);
        chk("sel_err_sticky", {31'd0, sel_err}, 32'd1);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        send(1'b0, 4'd0, D_STD, 32'h11);
        send(1'b0, 4'd1, D_STD, 32'h22);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_count", {16'd0, count}, 32'd0);
        chk("async_sel_err", {31'd0, sel_err}, 32'd0);
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("no_stale", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end

        // Sustained stream with count wrap
        t0 = cyc;
        for (int i = 0; i < 65537; i++) begin
            send(1'b0, 4'd0, {32'h44, 32'h33, 32'h22, 32'(i)}, 32'(i));
        end
        chk("stream_cycles", 32'(cyc - t0), 32'd65537);
        idle(1);
        chk("wrap_count", {16'd0, count}, 32'd1);
        chk("stream_drained", {31'd0, out_valid}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
